// File: rtl/xbar_slave_responder.sv
// Crossbar slave endpoint: req/ack request channel, word memory, and a fixed-latency
// in-order read response pipeline with a bounded number of outstanding reads.
module xbar_slave_responder #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_DEPTH       = 256,
  parameter int ACK_DELAY       = 0,
  parameter int RESP_DELAY      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cmd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic              resp_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  outstanding;
  logic [IDX_W-1:0]  idx;
  logic              rd_ok;
  logic              hs;
  logic              rd_hs;
  logic              wr_hs;
  logic              addr_unused;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              vld_q [RESP_DELAY];
  logic [DATA_W-1:0] dat_q [RESP_DELAY];
  logic [DATA_W-1:0] rdata_hold;

  assign idx         = addr_i[IDX_W+1:2];
  assign addr_unused = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};

  assign resp_o = vld_q[RESP_DELAY-1];
  // A response leaving this cycle frees its slot for a read accepted in the same cycle.
  assign rd_ok  = (outstanding < OUT_W'(MAX_OUTSTANDING)) || resp_o;
  assign ack_o  = req_i && (cnt == '0) && (cmd_i || rd_ok);
  assign hs     = req_i && ack_o;
  assign rd_hs  = hs && !cmd_i;
  assign wr_hs  = hs && cmd_i;

  // rdata_o shows the last stage while resp_o is high and holds that value afterwards.
  assign rdata_o = resp_o ? dat_q[RESP_DELAY-1] : rdata_hold;

  always_ff @(posedge clk) begin
    if (rst || !req_i || hs) begin
      cnt <= CNT_W'(ACK_DELAY);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_hs, resp_o})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem[idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < RESP_DELAY; k++) begin
        vld_q[k] <= 1'b0;
      end
      rdata_hold <= '0;
    end else begin
      vld_q[0] <= rd_hs;
      for (int unsigned k = 1; k < RESP_DELAY; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      if (resp_o) begin
        rdata_hold <= dat_q[RESP_DELAY-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dat_q[0] <= mem[idx];
    for (int unsigned k = 1; k < RESP_DELAY; k++) begin
      dat_q[k] <= dat_q[k-1];
    end
  end

endmodule

// File: tb/tb_xbar_slave_responder.sv
// Scoreboard bench for xbar_slave_responder: four instances cover the delay and
// outstanding-limit configurations; one monitor checks every response against a queue.
module tb_xbar_slave_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [4];
  logic        cmd   [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic        ack   [4];
  logic        resp  [4];
  logic [31:0] rdata [4];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int out2   = 0;
  int out2_max = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xbar_slave_responder #(.ACK_DELAY(0), .RESP_DELAY(2), .MAX_OUTSTANDING(4)) u0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr[0]), .cmd_i(cmd[0]),
    .wdata_i(wdata[0]), .ack_o(ack[0]), .resp_o(resp[0]), .rdata_o(rdata[0]));
  xbar_slave_responder #(.ACK_DELAY(3), .RESP_DELAY(2), .MAX_OUTSTANDING(4)) u1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr[1]), .cmd_i(cmd[1]),
    .wdata_i(wdata[1]), .ack_o(ack[1]), .resp_o(resp[1]), .rdata_o(rdata[1]));
  xbar_slave_responder #(.ACK_DELAY(0), .RESP_DELAY(4), .MAX_OUTSTANDING(2)) u2 (
    .clk(clk), .rst(rst), .req_i(req[2]), .addr_i(addr[2]), .cmd_i(cmd[2]),
    .wdata_i(wdata[2]), .ack_o(ack[2]), .resp_o(resp[2]), .rdata_o(rdata[2]));
  xbar_slave_responder #(.ACK_DELAY(0), .RESP_DELAY(1), .MAX_OUTSTANDING(1)) u3 (
    .clk(clk), .rst(rst), .req_i(req[3]), .addr_i(addr[3]), .cmd_i(cmd[3]),
    .wdata_i(wdata[3]), .ack_o(ack[3]), .resp_o(resp[3]), .rdata_o(rdata[3]));

  // Response monitor: every resp_o pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (resp[i] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut=%0d cyc=%0d rdata=%h expected no response", i, cyc, rdata[i]);
        end else begin
          e = sb.pop_front();
          if (e.id != i || e.data !== rdata[i] || e.due != cyc) begin
            errors++;
            $display("FAIL resp dut=%0d cyc=%0d rdata=%h expected dut=%0d cyc=%0d rdata=%h",
                     i, cyc, rdata[i], e.id, e.due, e.data);
          end
        end
      end
    end
  end

  // Independent tally of reads outstanding on u2 from its handshakes and responses.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      out2 = 0;
    end else begin
      if (req[2] === 1'b1 && ack[2] === 1'b1 && cmd[2] === 1'b0) out2 = out2 + 1;
      if (resp[2] === 1'b1) out2 = out2 - 1;
      if (out2 > out2_max) out2_max = out2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request on dut id; expects ack after exp_wait stalled cycles; reads with push
  // set enqueue their data due dly cycles after the handshake cycle.
  task automatic xfer(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int exp_wait, input int dly, input bit push);
    int waited = 0;
    bit got = 0;
    req[id] = 1'b1; cmd[id] = w; addr[id] = a; wdata[id] = w ? d : 32'h0;
    while (!got && waited <= 50) begin
      @(negedge clk);
      if (ack[id] === 1'b1) got = 1;
      else waited++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout dut=%0d addr=%h waited=%0d expected ack after %0d", id, a, waited, exp_wait);
    end else begin
      if (waited != exp_wait) begin
        errors++;
        $display("FAIL ack_wait dut=%0d addr=%h actual=%0d expected=%0d", id, a, waited, exp_wait);
      end
      if (!w && push) sb.push_back('{id: id, data: d, due: cyc + dly});
    end
    @(posedge clk);
    #1;
    req[id] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; cmd[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ack%0d", i), {31'b0, ack[i]}, 32'h0);
      chk($sformatf("reset_resp%0d", i), {31'b0, resp[i]}, 32'h0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Basic write then read, no stall
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 2, 1);
    xfer(0, 1'b0, 32'h10, 32'hDEADBEEF, 0, 2, 1);
    idle(5);

    // ACK_DELAY=3 on consecutive requests
    xfer(1, 1'b1, 32'h20, 32'h00001234, 3, 2, 1);
    xfer(1, 1'b0, 32'h20, 32'h00001234, 3, 2, 1);
    xfer(1, 1'b0, 32'h20, 32'h00001234, 3, 2, 1);
    idle(5);

    // Outstanding limit 2 with RESP_DELAY=4; a write slips in while the limit is reached
    xfer(2, 1'b1, 32'h0, 32'd1, 0, 4, 1);
    xfer(2, 1'b1, 32'h4, 32'd2, 0, 4, 1);
    xfer(2, 1'b1, 32'h8, 32'd3, 0, 4, 1);
    xfer(2, 1'b1, 32'hC, 32'd4, 0, 4, 1);
    xfer(2, 1'b0, 32'h0, 32'd1, 0, 4, 1);
    xfer(2, 1'b0, 32'h4, 32'd2, 0, 4, 1);
    xfer(2, 1'b1, 32'h40, 32'd5, 0, 4, 1);
    xfer(2, 1'b0, 32'h8, 32'd3, 1, 4, 1);
    xfer(2, 1'b0, 32'hC, 32'd4, 0, 4, 1);
    xfer(2, 1'b0, 32'h40, 32'd5, 2, 4, 1);
    idle(8);
    checks++;
    if (out2_max > 2) begin
      errors++;
      $display("FAIL outstanding_max actual=%0d expected<=2", out2_max);
    end

    // MAX_OUTSTANDING=1, RESP_DELAY=1: one read per cycle, writes interleaved
    xfer(3, 1'b1, 32'h0, 32'h11, 0, 1, 1);
    xfer(3, 1'b1, 32'h4, 32'h22, 0, 1, 1);
    xfer(3, 1'b1, 32'h8, 32'h33, 0, 1, 1);
    xfer(3, 1'b0, 32'h0, 32'h11, 0, 1, 1);
    xfer(3, 1'b0, 32'h4, 32'h22, 0, 1, 1);
    xfer(3, 1'b0, 32'h8, 32'h33, 0, 1, 1);
    xfer(3, 1'b1, 32'hC, 32'h44, 0, 1, 1);
    xfer(3, 1'b0, 32'hC, 32'h44, 0, 1, 1);
    idle(4);

    // Reset with two reads in flight: they must vanish, memory must survive
    xfer(2, 1'b0, 32'h0, 32'd1, 0, 4, 0);
    xfer(2, 1'b0, 32'h4, 32'd2, 0, 4, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_resp", {31'b0, resp[2]}, 32'h0);
    chk("post_reset_rdata", rdata[2], 32'h0);
    idle(6);
    chk("post_reset_rdata_idle", rdata[2], 32'h0);
    xfer(2, 1'b0, 32'h0, 32'd1, 0, 4, 1);
    xfer(2, 1'b0, 32'h8, 32'd3, 0, 4, 1);
    idle(8);

    // Address aliasing modulo MEM_DEPTH*4 and byte-offset ignore
    xfer(0, 1'b1, 32'h400, 32'hA5A5A5A5, 0, 2, 1);
    xfer(0, 1'b0, 32'h000, 32'hA5A5A5A5, 0, 2, 1);
    xfer(0, 1'b0, 32'h003, 32'hA5A5A5A5, 0, 2, 1);
    idle(6);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_resp pending=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbar_slave_responder.md
Name: xbar_slave_responder

Overview:
- Synthesizable slave endpoint for one crossbar slave port; the responder side of the request/response protocol the crossbar masters initiate.
- Accepts read/write requests through the req/ack handshake and stores writes in an internal word memory.
- Returns read data on the resp channel after a fixed latency, with a bounded number of outstanding reads.
- Serves as the RTL slave model behind the crossbar in system benches and as the reference slave for integration.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, write/read data width
MEM_DEPTH, 256, memory depth in words (power of 2)
ACK_DELAY, 0, stall cycles before a pending request is acknowledged
RESP_DELAY, 2, cycles from read handshake to resp_o (>=1)
MAX_OUTSTANDING, 4, maximum reads acknowledged but not yet responded (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  request valid, held until ack
addr_i  in  ADDR_W  byte address
cmd_i  in  1  0=read, 1=write
wdata_i  in  DATA_W  write data
ack_o  out  1  request accepted this cycle
resp_o  out  1  read response valid, one-cycle pulse
rdata_o  out  DATA_W  read response data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ack_o=0, resp_o=0, rdata_o=0.
  - Reset clears the delay counter, the response pipeline and the outstanding counter.
  - Memory contents are not cleared by reset.
- Handshake: a transfer occurs on a rising clk edge where req_i=1 and ack_o=1.
  - ack_o = req_i & (cnt==0) & (cmd_i | rd_ok). It is combinational from the inputs and registered state.
  - The master holds addr/cmd/wdata stable while req_i=1. The block does not check this.
- Stall counter cnt:
  - Loaded with ACK_DELAY at reset, on every handshake, and in any cycle with req_i=0.
  - Decrements each cycle req_i=1 and cnt!=0.
  - ACK_DELAY=0 gives ack in the first cycle of req.
  - ACK_DELAY=N gives ack in the (N+1)th consecutive req cycle.
- rd_ok = (outstanding < MAX_OUTSTANDING) | resp_o. A response leaving in the same cycle frees a slot.
- Address map: word index = addr_i[log2(MEM_DEPTH)+1:2]. Upper bits and addr_i[1:0] are ignored, so addresses alias modulo MEM_DEPTH*4.
- Write: on handshake with cmd_i=1, mem[index] <= wdata_i. No response is produced.
- Read:
  - On handshake with cmd_i=0, mem[index] is sampled in that cycle and enters a RESP_DELAY-stage valid/data shift pipeline.
  - The last stage drives resp_o. rdata_o loads on resp_o and holds its value otherwise.
  - resp_o rises exactly RESP_DELAY cycles after the handshake edge.
  - Responses are strictly in order, at most one per cycle. Back-to-back reads give back-to-back responses.
- Read-after-write: a write at edge N followed by a read of the same index at edge N+1 returns the new data.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on read handshake, -1 on resp_o.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Throughput: if MAX_OUTSTANDING < RESP_DELAY, read acceptance is throttled; it is not an error.
- Reset mid-operation: in-flight reads are discarded and produce no resp_o after reset. The first request after reset sees the full ACK_DELAY.
- Writes during full outstanding: writes are not blocked by the outstanding limit.

Test Plan:
1. ACK_DELAY=0, RESP_DELAY=2: write 0x10 <- 0xDEADBEEF, then read 0x10.
   -> ack_o high in the first req cycle of each request.
   -> resp_o pulses 2 cycles after the read handshake with rdata_o=0xDEADBEEF.
   -> No resp_o for the write.
2. ACK_DELAY=3: hold a read req from cycle 0.
   -> ack_o=0 in cycles 0-2 and 1 in cycle 3.
   -> A second request issued immediately after also waits 3 cycles.
3. MAX_OUTSTANDING=2, RESP_DELAY=4: four reads of 0x0/0x4/0x8/0xC preloaded with 1,2,3,4.
   -> Third ack is withheld until the first resp_o cycle.
   -> Responses arrive in order with rdata 1,2,3,4.
   -> Outstanding counter never exceeds 2.
4. MAX_OUTSTANDING=1, RESP_DELAY=1: continuous reads.
   -> Each ack coincides with the previous read's resp_o, giving one read per cycle after the first.
   -> Writes interleaved while outstanding=1 are acked with no stall.
5. Assert rst for 1 cycle while 2 reads are in the pipeline.
   -> No resp_o afterwards; rdata_o=0.
   -> Next read is acked and responds normally.
   -> Memory retains pre-reset data.
6. MEM_DEPTH=256: write 0x400 <- 0xA5A5A5A5, read 0x000 and 0x003.
   -> Both return 0xA5A5A5A5 (aliasing and byte-offset ignore).
